// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply, restoring divide, start/busy/done handshake.
module alu_muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic [XLEN-1:0] result
);
   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t            state, state_nxt;
   logic [2:0]        op;
   logic [XLEN-1:0]   bq;
   logic [2*XLEN-1:0] acc;
   logic [CNT_W-1:0]  cnt;
   logic              neg_q, neg_r;
   logic [XLEN-1:0]   res_q;
   logic              illegal_q;

   logic              legal, accept, fast;
   logic              sgn_a, sgn_b, sa, sb, div0, ovf;
   logic [XLEN-1:0]   a_mag, b_mag, quo, rem, fin_val;
   logic [XLEN:0]     mul_sum, div_t, div_d;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;

   assign legal  = funct7 == 7'b0000001;
   assign accept = state == IDLE && start && !flush;

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn_a = 1'b1;
            sgn_b = 1'b1;
         end
         3'b010:  sgn_a = 1'b1;
         default: ;
      endcase
   end

   assign sa    = sgn_a && rs1_val[XLEN-1];
   assign sb    = sgn_b && rs2_val[XLEN-1];
   assign a_mag = sa ? -rs1_val : rs1_val;
   assign b_mag = sb ? -rs2_val : rs2_val;
   assign div0  = rs2_val == '0;
   assign ovf   = funct3[2] && sgn_a && (&rs2_val)
                  && rs1_val == {1'b1, {(XLEN-1){1'b0}}};
   assign fast  = funct3[2] && (div0 || ovf);

   // acc = {partial product, remaining multiplier bits}
   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                    + (acc[0] ? {1'b0, bq} : '0);
   assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

   // acc = {partial remainder, dividend bits / quotient bits}
   assign div_t   = acc[2*XLEN-1:XLEN-1];
   assign div_ge  = div_t >= {1'b0, bq};
   assign div_d   = div_t - {1'b0, bq};
   assign div_nxt = div_ge
                    ? {div_d[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                    : {div_t[XLEN-1:0], acc[XLEN-2:0], 1'b0};

   assign prod = neg_q ? -acc : acc;
   assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

   always_comb begin
      fin_val = '0;
      case (op)
         3'b000:                 fin_val = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_val = quo;
         default:                fin_val = rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (start && legal)
               state_nxt = !funct3[2] ? MUL : (fast ? FIN : DIV);
            MUL, DIV: if (cnt == '0) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op        <= '0;
         bq        <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         res_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept && !legal;
         if (accept && legal) begin
            op    <= funct3;
            cnt   <= CNT_LAST;
            neg_q <= fast ? 1'b0 : sa ^ sb;
            neg_r <= fast ? 1'b0 : sa;
            // fast paths preload {remainder, quotient} directly
            if (!funct3[2]) begin
               acc <= {{XLEN{1'b0}}, b_mag};
               bq  <= a_mag;
            end else if (div0) begin
               acc <= {rs1_val, {XLEN{1'b1}}};
            end else if (ovf) begin
               acc <= {{XLEN{1'b0}}, rs1_val};
            end else begin
               acc <= {{XLEN{1'b0}}, a_mag};
               bq  <= b_mag;
            end
         end else if (!flush) begin
            if (state == MUL) acc <= mul_nxt;
            if (state == DIV) acc <= div_nxt;
            if ((state == MUL || state == DIV) && cnt != '0)
               cnt <= cnt - CNT_ONE;
            if (state == FIN) res_q <= fin_val;
         end
      end
   end

   assign busy    = state != IDLE;
   assign done    = state == FIN;
   assign illegal = illegal_q;
   assign result  = done ? fin_val : res_q;

endmodule
